mem_port_arbiter: RTL and testbench

Shares the single main-memory port between instruction-cache line fills and data-cache fills and write-backs. Each transaction is latched at grant, driven to memory and held until the memory answers. The arbiter returns a registered one-cycle done pulse to the owning cache. The caches use done to release their block_pipe_* stall outputs toward the pipeline control unit.

---
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - main-memory port arbiter for icache fills and dcache fills/write-backs
//
// Grants the single memory port to one cache at a time. The winner's request
// is latched at grant and driven to memory until mem_ready, or until TIMEOUT
// cycles pass, which completes the transaction with an error. Completion is
// reported with a registered one-cycle done pulse to the owning cache.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ic_req/ic_addr              icache read request (level, held until ic_done)
//   ic_done/ic_err/ic_rdata     icache completion pulse, timeout flag, read line
//   dc_req/dc_we/dc_addr/dc_wdata  dcache request (fill or write-back)
//   dc_done/dc_err/dc_rdata     dcache completion pulse, timeout flag, read line
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until ready/timeout
//   mem_rdata/mem_ready         memory read data and one-cycle completion
//   busy, owner                 not-idle flag, current/last grant (1 = dcache)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic              ic_err,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic              dc_err,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    // The last grant doubles as the owner output; both are the same register.
    assign owner       = last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // On a tie the requester that did not win last time is served.
                if (ic_req && dc_req) begin
                    state_next = last_grant ? GRANT_I : GRANT_D;
                end else if (dc_req) begin
                    state_next = GRANT_D;
                end else if (ic_req) begin
                    state_next = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs. Done pulses are set on the GRANT->RESP transition
    // and cleared by default on the following edge, so they last one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            ic_done    <= 1'b0;
            ic_err     <= 1'b0;
            ic_rdata   <= '0;
            dc_done    <= 1'b0;
            dc_err     <= 1'b0;
            dc_rdata   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            busy    <= (state_next != IDLE);
            ic_done <= 1'b0;
            dc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_next == GRANT_I) begin
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= ic_addr;
                        mem_wdata  <= '0;
                        last_grant <= 1'b0;
                        cnt        <= '0;
                    end else if (state_next == GRANT_D) begin
                        mem_req    <= 1'b1;
                        mem_we     <= dc_we;
                        mem_addr   <= dc_addr;
                        mem_wdata  <= dc_wdata;
                        last_grant <= 1'b1;
                        cnt        <= '0;
                    end
                end
                GRANT_I: begin
                    if (mem_ready) begin
                        ic_rdata <= mem_rdata;
                        ic_err   <= 1'b0;
                        ic_done  <= 1'b1;
                        mem_req  <= 1'b0;
                    end else if (timeout_hit) begin
                        ic_rdata <= '0;
                        ic_err   <= 1'b1;
                        ic_done  <= 1'b1;
                        mem_req  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GRANT_D: begin
                    if (mem_ready) begin
                        // Write-backs return no data.
                        dc_rdata <= mem_we ? '0 : mem_rdata;
                        dc_err   <= 1'b0;
                        dc_done  <= 1'b1;
                        mem_req  <= 1'b0;
                    end else if (timeout_hit) begin
                        dc_rdata <= '0;
                        dc_err   <= 1'b1;
                        dc_done  <= 1'b1;
                        mem_req  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_done;
    logic              ic_err;
    logic [LINE_W-1:0] ic_rdata;
    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_done;
    logic              dc_err;
    logic [LINE_W-1:0] dc_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic              owner;

    typedef struct {
        logic              own;
        logic              err;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_done  (ic_done),
        .ic_err   (ic_err),
        .ic_rdata (ic_rdata),
        .dc_req   (dc_req),
        .dc_we    (dc_we),
        .dc_addr  (dc_addr),
        .dc_wdata (dc_wdata),
        .dc_done  (dc_done),
        .dc_err   (dc_err),
        .dc_rdata (dc_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .owner    (owner)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until mem_req is seen, bounded.
    task automatic wait_grant(input string tag);
        int b = 0;
        while (!mem_req && b < 20) begin
            step();
            b++;
        end
        chk1(tag, mem_req, 1'b1);
    endtask

    // Called in the first mem_req cycle; answers after lat cycles and
    // returns in the cycle where done should be visible.
    task automatic respond(input int lat, input logic [LINE_W-1:0] d);
        repeat (lat - 1) step();
        mem_ready = 1'b1;
        mem_rdata = d;
        step();
        mem_ready = 1'b0;
        mem_rdata = {4{32'h0BAD_F00D}};
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!reset && (ic_done || dc_done)) begin
            chk1("done_exclusive", ic_done & dc_done, 1'b0);
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_done: observed ic_done=%0b dc_done=%0b expected none", ic_done, dc_done);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk1("done_owner", dc_done, mon_e.own);
                chk1("done_err", dc_done ? dc_err : ic_err, mon_e.err);
                chkw("done_rdata", dc_done ? dc_rdata : ic_rdata, mon_e.data);
            end
        end
    end

    initial begin
        logic [LINE_W-1:0] d1;
        logic [LINE_W-1:0] wb;
        int                hi;
        reset     = 1'b1;
        ic_req    = 1'b0;
        ic_addr   = '0;
        dc_req    = 1'b0;
        dc_we     = 1'b0;
        dc_addr   = '0;
        dc_wdata  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        step();
        step();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_done", ic_done | dc_done, 1'b0);
        chkw("rst_mem_addr", LINE_W'(mem_addr), '0);
        chkw("rst_ic_rdata", ic_rdata, '0);
        reset = 1'b0;
        step();

        // 1: single icache fill, memory answers on the 4th request cycle
        d1      = {32'hDEADBEEF, 64'h0, 32'h00000001};
        ic_req  = 1'b1;
        ic_addr = 32'h0000_1000;
        step();
        chk1("t1_mem_req_c1", mem_req, 1'b1);
        chkw("t1_mem_addr", LINE_W'(mem_addr), LINE_W'(32'h1000));
        chk1("t1_mem_we", mem_we, 1'b0);
        chk1("t1_busy", busy, 1'b1);
        chk1("t1_owner", owner, 1'b0);
        step();
        step();
        chk1("t1_mem_req_c3", mem_req, 1'b1);
        sb.push_back('{own: 1'b0, err: 1'b0, data: d1});
        respond(2, d1);
        chk1("t1_ic_done_c5", ic_done, 1'b1);
        chk1("t1_mem_req_c5", mem_req, 1'b0);
        ic_req = 1'b0;
        step();
        chk1("t1_busy_c6", busy, 1'b0);
        chk1("t1_ic_done_c6", ic_done, 1'b0);
        chkw("t1_rdata_hold", ic_rdata, d1);

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk1("idle_ready_busy", busy, 1'b0);
        step();

        // 2: tie after a fresh reset goes to dcache first
        reset = 1'b1;
        step();
        reset  = 1'b0;
        ic_req = 1'b1;
        dc_req = 1'b1;
        dc_we  = 1'b0;
        dc_addr = 32'h0000_3000;
        ic_addr = 32'h0000_4000;
        step();
        chk1("t2_owner_d", owner, 1'b1);
        chkw("t2_addr_d", LINE_W'(mem_addr), LINE_W'(32'h3000));
        sb.push_back('{own: 1'b1, err: 1'b0, data: {4{32'h1111_2222}}});
        respond(1, {4{32'h1111_2222}});
        chk1("t2_dc_done", dc_done, 1'b1);
        dc_req = 1'b0;
        step();
        wait_grant("t2_grant_i");
        chk1("t2_owner_i", owner, 1'b0);
        chkw("t2_addr_i", LINE_W'(mem_addr), LINE_W'(32'h4000));
        sb.push_back('{own: 1'b0, err: 1'b0, data: {4{32'h3333_4444}}});
        respond(1, {4{32'h3333_4444}});
        chk1("t2_ic_done", ic_done, 1'b1);
        ic_req = 1'b0;
        step();
        step();

        // 3: both requesting continuously, grants alternate D,I,D,I,D,I
        ic_req = 1'b1;
        dc_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [LINE_W-1:0] d;
            d = {96'h0, 32'hC0DE_0000 + 32'(i)};
            wait_grant("t3_grant");
            chk1("t3_owner", owner, (i % 2) == 0);
            sb.push_back('{own: (i % 2) == 0, err: 1'b0, data: d});
            respond((i % 3) + 1, d);
            chk1("t3_done", ic_done | dc_done, 1'b1);
            step();
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        step();
        step();

        // 4: dcache write-back, request inputs change after grant
        wb       = {16{8'hA5}};
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = 32'h0000_2040;
        dc_wdata = wb;
        step();
        chk1("t4_mem_we", mem_we, 1'b1);
        dc_addr  = 32'h0000_FFFF;
        dc_wdata = '0;
        step();
        chkw("t4_mem_addr_hold", LINE_W'(mem_addr), LINE_W'(32'h2040));
        chkw("t4_mem_wdata_hold", mem_wdata, wb);
        sb.push_back('{own: 1'b1, err: 1'b0, data: '0});
        respond(1, {4{32'h7777_8888}});
        chk1("t4_dc_done", dc_done, 1'b1);
        dc_req = 1'b0;
        dc_we  = 1'b0;
        step();
        step();

        // 5: timeout after exactly TIMEOUT request cycles, then ready on the last cycle
        ic_req  = 1'b1;
        ic_addr = 32'h0000_5000;
        sb.push_back('{own: 1'b0, err: 1'b1, data: '0});
        step();
        hi = 0;
        while (mem_req && hi < 10) begin
            hi++;
            step();
        end
        chkw("t5_mem_req_cycles", LINE_W'(hi), LINE_W'(TIMEOUT));
        chk1("t5_ic_done", ic_done, 1'b1);
        chk1("t5_ic_err", ic_err, 1'b1);
        ic_req = 1'b0;
        step();
        step();
        ic_req = 1'b1;
        step();
        chk1("t5b_mem_req", mem_req, 1'b1);
        sb.push_back('{own: 1'b0, err: 1'b0, data: {4{32'h5A5A_0004}}});
        respond(TIMEOUT, {4{32'h5A5A_0004}});
        chk1("t5b_ic_done", ic_done, 1'b1);
        chk1("t5b_ic_err", ic_err, 1'b0);
        ic_req = 1'b0;
        step();
        step();

        // 6: reset during GRANT_D aborts without a done pulse
        dc_req  = 1'b1;
        dc_addr = 32'h0000_6000;
        step();
        chk1("t6_grant_d", mem_req & owner, 1'b1);
        reset = 1'b1;
        step();
        reset  = 1'b0;
        dc_req = 1'b0;
        chk1("t6_mem_req", mem_req, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        repeat (6) step();
        dc_req = 1'b1;
        step();
        chk1("t6b_grant", mem_req & owner, 1'b1);
        sb.push_back('{own: 1'b1, err: 1'b0, data: {4{32'h6666_0001}}});
        respond(2, {4{32'h6666_0001}});
        chk1("t6b_dc_done", dc_done, 1'b1);
        dc_req = 1'b0;
        step();
        step();

        chk1("sb_empty", sb.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
